pattern_chain_pipe: RTL and testbench
=====================================

# pattern_chain_pipe

Parametrised, elastic successor to the fixed two-pattern merged netlists. It chains `NUM_STAGES` registered pattern cells, each operating bitwise on `W`-bit vectors, with a valid/ready handshake and per-transaction mode selection. It provides backpressure, bubble collapsing and an output transaction counter, none of which the flat merged netlists have. It sits between pattern-source logic and downstream consumers in generated merged-graph designs.

## Interface
Parameters:
- `W`, default 4: data width of each vector.
- `NUM_STAGES`, default 2: number of pattern stages; minimum 1.
- `CNT_W`, default 8: width of the output transaction counter.

Ports:
- `blif_clk_net`, input, 1: the single clock; all state updates on its rising edge.
- `blif_reset_net`, input, 1: reset. **One clock; reset is synchronous and active-high.**
- `in_valid`, input, 1: the input transaction is present.
- `in_ready`, output, 1: stage 0 can accept a transaction this cycle.
- `in_p`, `in_q`, `in_r`, input, W each: input vectors.
- `in_mode`, input, 1: cell mode for this transaction; it travels with the data.
- `out_valid`, output, 1: the last stage holds a transaction.
- `out_ready`, input, 1: the consumer accepts the transaction this cycle.
- `out_p`, `out_q`, `out_r`, output, W each: vectors held in the last stage.
- `out_cnt`, output, CNT_W: count of accepted output transactions, modulo 2^CNT_W.

## Operation
Per-stage state for stage s:
- `v[s]` (valid), `p[s]`, `q[s]`, `r[s]` (W bits each), `m[s]` (mode).
- The stage input (pi, qi, ri, mi) is the input ports for s=0 and the registers of stage s-1 otherwise.

Cell function when stage s loads, bitwise over W:
- p <= pi & qi
- q <= ~(pi | ri)
- r <= mi ? (ri | (pi & qi)) : (ri & ~(pi & qi))
- m <= mi

Handshake and flow:
- `ld[s]` = `v[s]` is 0 OR stage s+1 loads. For the last stage, "stage s+1 loads" means `out_ready`.
- `in_ready` = `ld[0]`, a combinational ready chain.
- Stage 0 loads its data when `ld[0]` is set. It sets `v[0]` <= `in_valid`.
- Stage s>0 loads when `ld[s]` is set. It sets `v[s]` <= `v[s-1]`. Data is captured even when the incoming valid is 0, so the data of an invalid stage is don't-care.
- Bubbles collapse: an empty stage always accepts from upstream, even when downstream is stalled.
- `out_valid` = `v[last]`; `out_p`/`out_q`/`out_r` = the last-stage registers.

Counter:
- `out_cnt` increments by 1 on every cycle where `out_valid` and `out_ready` are both 1.
- It wraps from 2^CNT_W-1 to 0 with no flag.

Reset (synchronous, high):
- All `v`, `p`, `q`, `r`, `m` registers and `out_cnt` clear to 0.
- After reset: `out_valid`=0, outputs 0, `out_cnt`=0, `in_ready`=1.
- A reset asserted mid-stream discards all in-flight transactions. It does not increment `out_cnt`, even if `out_ready` is high that cycle.

## Timing
- Latency: a transaction accepted at edge k appears on `out_*` with `out_valid`=1 after edge k+NUM_STAGES-1, i.e. in the cycle following NUM_STAGES accepting edges, when there are no stalls.
- Throughput: one transaction per cycle while `out_ready`=1.
- Stall: with `out_ready`=0, the pipeline absorbs up to NUM_STAGES transactions. After that, `in_ready`=0 in the same cycle; there is no registered lag.
- Simultaneous full-pipe pop and push: when `out_ready`=1 and all stages are valid, `in_ready`=1 and the pipe advances with no bubble.
- Output stability: `out_*` is held unchanged while `out_valid`=1 and `out_ready`=0.
- `in_ready` does not depend on `in_valid`.

## Test plan
- **Reset:** assert `blif_reset_net` for 2 cycles with random inputs -> `out_valid`=0, `out_p`/`out_q`/`out_r`=0, `out_cnt`=0, `in_ready`=1.
- **Mode 0 datapath:** W=4, NUM_STAGES=2, `out_ready`=1, single push of p=1100, q=1010, r=0110, mode=0 -> two cycles later, `out_p`=0000, `out_q`=0001, `out_r`=0110, `out_cnt`=1.
- **Mode 1 datapath:** same vectors with mode=1 -> `out_p`=0000, `out_q`=0001, `out_r`=1110.
- **Backpressure:** `out_ready`=0, `in_valid`=1 continuously:
  - `in_ready` drops after exactly 2 accepts.
  - Outputs remain stable for 10 cycles.
  - Releasing `out_ready` delivers all transactions in order with no loss or duplication.
- **Bubble collapse and streaming:** push on alternate cycles with `out_ready` toggling randomly, 1000 transactions checked against a reference model -> in-order data match, and `out_cnt` equals the accepted count mod 256.
- **Wrap and mid-reset:**
  - CNT_W=3: stream 9 transactions -> `out_cnt`=1.
  - Then reset with 2 transactions in flight -> both are discarded, and `out_valid`=0 on the next cycle.

Source files
------------

// File: rtl/pattern_chain_pipe.sv
// -----------------------------------------------------------------------------
// pattern_chain_pipe
//
// Elastic chain of NUM_STAGES registered pattern cells. Each cell works
// bitwise on three W-bit vectors (p, q, r) plus a mode bit that travels with
// the data. Stages are linked with a valid/ready handshake whose ready path is
// purely combinational, so empty stages (bubbles) always accept from upstream
// and a full pipe can pop and push in the same cycle. The number of
// transactions accepted at the output is counted modulo 2^CNT_W.
//
// Ports
//   blif_clk_net    in   1      single clock, rising edge
//   blif_reset_net  in   1      synchronous active-high reset
//   in_valid        in   1      input transaction present
//   in_ready        out  1      stage 0 accepts this cycle
//   in_p/q/r        in   W      input vectors
//   in_mode         in   1      cell mode for this transaction
//   out_valid       out  1      last stage holds a transaction
//   out_ready       in   1      consumer accepts this cycle
//   out_p/q/r       out  W      last-stage vectors
//   out_cnt         out  CNT_W  accepted output transactions, wrapping
// -----------------------------------------------------------------------------
module pattern_chain_pipe #(
    parameter int W          = 4,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_p,
    input  logic [W-1:0]     in_q,
    input  logic [W-1:0]     in_r,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_p,
    output logic [W-1:0]     out_q,
    output logic [W-1:0]     out_r,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int LAST = NUM_STAGES - 1;

    // Payload carried by one stage: the three vectors and the mode bit.
    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         m;
    } cell_t;

    // One pattern cell: maps a stage input to the value the stage stores.
    function automatic cell_t cell_fn(input cell_t x);
        cell_t        y;
        logic [W-1:0] pq;
        pq  = x.p & x.q;
        y.p = pq;
        y.q = ~(x.p | x.r);
        y.r = x.m ? (x.r | pq) : (x.r & ~pq);
        y.m = x.m;
        return y;
    endfunction

    logic  [NUM_STAGES-1:0] v_q, v_d;
    cell_t [NUM_STAGES-1:0] st_q, st_d;
    logic  [CNT_W-1:0]      cnt_q, cnt_d;
    logic  [NUM_STAGES-1:0] ld;
    cell_t                  in_cell;

    assign in_cell = '{p: in_p, q: in_q, r: in_r, m: in_mode};

    // Ready chain, evaluated from the output back to the input. A stage loads
    // when it is empty or its successor loads, so a single out_ready reaches
    // in_ready in the same cycle with no registered lag.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (here a default first); otherwise synthesis infers a latch.
        ld       = '0;
        ld[LAST] = ~v_q[LAST] | out_ready;
        for (int s = LAST - 1; s >= 0; s--) begin
            ld[s] = ~v_q[s] | ld[s + 1];
        end
    end

    // Next-state for the stages and the counter. Data is captured whenever a
    // stage loads, even if the incoming valid is low; the payload of an
    // invalid stage is never observed.
    always_comb begin
        v_d  = v_q;
        st_d = st_q;
        if (ld[0]) begin
            v_d[0]  = in_valid;
            st_d[0] = cell_fn(in_cell);
        end
        for (int s = 1; s < NUM_STAGES; s++) begin
            if (ld[s]) begin
                v_d[s]  = v_q[s - 1];
                st_d[s] = cell_fn(st_q[s - 1]);
            end
        end
        cnt_d = cnt_q + CNT_W'(v_q[LAST] & out_ready);
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            // NOTE: the payload registers are cleared along with the valid
            // bits so the outputs read as zero straight after reset, not just
            // out_valid.
            v_q   <= '0;
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so that every
            // stage samples its predecessor's pre-edge value.
            v_q   <= v_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LAST];
    assign out_p     = st_q[LAST].p;
    assign out_q     = st_q[LAST].q;
    assign out_r     = st_q[LAST].r;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_pattern_chain_pipe.sv
// -----------------------------------------------------------------------------
// tb_pattern_chain_pipe
//
// Drives two instances sharing all inputs: one with the default 8-bit counter
// and one with a 3-bit counter for the wrap case. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Expected output vectors come from a transaction-level model that applies the
// cell rules NUM_STAGES times to each accepted input and queues the result.
// -----------------------------------------------------------------------------
module tb_pattern_chain_pipe;

    localparam int W  = 4;
    localparam int NS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_p, in_q, in_r;
    logic         in_mode;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_p, a_out_q, a_out_r;
    logic [7:0]   a_out_cnt;
    logic         b_in_ready, b_out_valid;
    logic [W-1:0] b_out_p, b_out_q, b_out_r;
    logic [2:0]   b_out_cnt;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int pops = 0;
    logic [3*W-1:0] sb[$];

    always #5 clk = ~clk;

    pattern_chain_pipe #(.W(W), .NUM_STAGES(NS), .CNT_W(8)) dut_a (
        .blif_clk_net(clk), .blif_reset_net(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_p(in_p), .in_q(in_q), .in_r(in_r), .in_mode(in_mode),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_p(a_out_p), .out_q(a_out_q), .out_r(a_out_r),
        .out_cnt(a_out_cnt)
    );

    pattern_chain_pipe #(.W(W), .NUM_STAGES(NS), .CNT_W(3)) dut_b (
        .blif_clk_net(clk), .blif_reset_net(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_p(in_p), .in_q(in_q), .in_r(in_r), .in_mode(in_mode),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_p(b_out_p), .out_q(b_out_q), .out_r(b_out_r),
        .out_cnt(b_out_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-pipe transfer function: the cell rules applied once per stage.
    function automatic logic [3*W-1:0] ref_out(input logic [W-1:0] p, q, r, input logic m);
        logic [W-1:0] a, b, c, pq;
        a = p; b = q; c = r;
        for (int i = 0; i < NS; i++) begin
            pq = a & b;
            b  = ~(a | c);
            c  = m ? (c | pq) : (c & ~pq);
            a  = pq;
        end
        return {a, b, c};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] p, q, r, input logic m, input logic ordy);
        in_valid = v; in_p = p; in_q = q; in_r = r; in_mode = m; out_ready = ordy;
    endtask

    task automatic drive_rand(input logic v, input logic ordy);
        drive(v, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), ordy);
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    // Records the handshakes that the coming rising edge will perform.
    task automatic cycle();
        logic [3*W-1:0] exp;
        #1;
        if (!rst) begin
            if (a_out_valid && out_ready) begin
                check("pop_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("out_data_a", 32'({a_out_p, a_out_q, a_out_r}), 32'(exp));
                    check("out_data_b", 32'({b_out_p, b_out_q, b_out_r}), 32'(exp));
                end
                pops++;
            end
            if (in_valid && a_in_ready) begin
                sb.push_back(ref_out(in_p, in_q, in_r, in_mode));
                accepts++;
            end
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            pops = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) cycle();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        rst = 1'b1;
        drive_rand(1'b1, 1'b1);
        @(negedge clk);

        // Reset for two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'($urandom), 1'($urandom));
            cycle();
        end
        #1;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", 32'({a_out_p, a_out_q, a_out_r}), 32'd0);
        check("rst_cnt_a", 32'(a_out_cnt), 32'd0);
        check("rst_cnt_b", 32'(b_out_cnt), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        rst = 1'b0;

        // Mode 0 single push.
        drive(1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        check("m0_out_valid", 32'(a_out_valid), 32'd1);
        check("m0_out_p", 32'(a_out_p), 32'b0000);
        check("m0_out_q", 32'(a_out_q), 32'b0001);
        check("m0_out_r", 32'(a_out_r), 32'b0110);
        cycle();
        #1;
        check("m0_cnt", 32'(a_out_cnt), 32'd1);
        check("m0_drained", 32'(a_out_valid), 32'd0);

        // Mode 1 single push.
        drive(1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        check("m1_out_valid", 32'(a_out_valid), 32'd1);
        check("m1_out_p", 32'(a_out_p), 32'b0000);
        check("m1_out_q", 32'(a_out_q), 32'b0001);
        check("m1_out_r", 32'(a_out_r), 32'b1110);
        cycle();
        #1;
        check("m1_cnt", 32'(a_out_cnt), 32'd2);

        // Backpressure: in_ready falls after exactly NS accepts.
        acc0 = accepts;
        for (int i = 0; i < 12; i++) begin
            drive_rand(1'b1, 1'b0);
            cycle();
        end
        check("bp_accepts", 32'(accepts - acc0), 32'(NS));
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'($urandom), 1'b0);
            #1;
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_stable", 32'({a_out_p, a_out_q, a_out_r}), 32'(sb[0]));
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            cycle();
        end
        // Full pipe with out_ready high: push and pop in the same cycle.
        drive_rand(1'b1, 1'b1);
        #1;
        check("full_pop_push", 32'(a_in_ready), 32'd1);
        cycle();
        drain();
        check("bp_delivered", 32'(pops), 32'd5);

        // Randomised streaming with bubbles.
        acc0 = accepts;
        for (int c = 0; c < 20000 && (accepts - acc0) < 1000; c++) begin
            drive_rand(1'(c % 2 == 0), 1'($urandom_range(0, 1)));
            cycle();
        end
        check("stream_accepts", 32'(accepts - acc0), 32'd1000);
        drain();
        #1;
        check("stream_cnt_a", 32'(a_out_cnt), 32'(pops % 256));
        check("stream_cnt_b", 32'(b_out_cnt), 32'(pops % 8));

        // Counter wrap with the 3-bit instance.
        rst = 1'b1;
        drive_rand(1'b1, 1'b1);
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_rand(1'b1, 1'b1);
            cycle();
        end
        drain();
        #1;
        check("wrap_cnt_b", 32'(b_out_cnt), 32'd1);
        check("wrap_cnt_a", 32'(a_out_cnt), 32'd9);

        // Reset with two transactions in flight.
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1, 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("mid_full", 32'(a_out_valid), 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("mid_out_valid", 32'(a_out_valid), 32'd0);
        check("mid_cnt_a", 32'(a_out_cnt), 32'd0);
        check("mid_cnt_b", 32'(b_out_cnt), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("mid_discarded", 32'(a_out_valid), 32'd0);
        check("mid_cnt_after", 32'(a_out_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
